count_seq_checker: RTL
======================

// Module: count_seq_checker
// PURPOSE
//  Receive-side monitor for the 3-bit free-running counter outputs {a,b,c}.
//  Samples the count every clk, locks onto a valid +1 (mod 8) sequence, then
//  flags skips/stalls, counts errors and wraps. Sits beside the counter in the
//  same clk domain, for on-chip self-check and as the bench's scoreboard.
// PARAMETERS
//  LOCK_CNT     4  consecutive correct increments needed to assert locked (1..15)
//  UNLOCK_ERRS  2  consecutive errors while locked that drop lock (1..15)
//  CNT_W        8  width of err_count and wrap_count (saturating)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  a           in   1      count bit 2 (MSB), synchronous to clk
//  b           in   1      count bit 1
//  c           in   1      count bit 0 (LSB)
//  locked      out  1      sequence acquired and tracking
//  err_pulse   out  1      one-cycle strobe: mismatch seen while locked
//  wrap_pulse  out  1      one-cycle strobe: 7->0 transition seen while locked
//  err_count   out  CNT_W  total errors since reset, saturates at all-ones
//  wrap_count  out  CNT_W  total wraps since reset, saturates at all-ones
// BEHAVIOUR
//  - One clock (clk); reset is synchronous, active-high (rst). No async paths.
//  - Reset: state=SEEK; cur_q, prev_q, match_cnt, miss_cnt = 0; all outputs 0.
//  - Edge N: cur_q <= {a,b,c}; prev_q <= cur_q. Compare cur_q vs prev_q+1 mod 8
//    (3-bit add, carry dropped). Compare results registered at edge N+1, so
//    outputs lag the input value by 2 clks.
//  - FSM states SEEK, ACQ, LOCKED:
//    SEEK: first post-reset sample only fills cur_q; next edge -> ACQ, match_cnt=0.
//    ACQ: correct step -> match_cnt+1; at match_cnt==LOCK_CNT -> LOCKED,
//      locked=1, miss_cnt=0. Incorrect -> match_cnt=0, stay ACQ. No err/wrap
//      pulses or count changes in SEEK/ACQ.
//    LOCKED: correct step -> miss_cnt=0; 7->0 step also gives wrap_pulse=1,
//      wrap_count+1. Incorrect (skip, stall cur==prev, backward) -> err_pulse=1,
//      err_count+1, miss_cnt+1; if miss_cnt reaches UNLOCK_ERRS -> ACQ,
//      locked=0 that same cycle, match_cnt=0.
//  - err_pulse and wrap_pulse are mutually exclusive and never high 2 cycles
//    unless the triggering event recurs on consecutive samples.
//  - Counters saturate: at all-ones, further events still pulse, count holds.
//  - rst mid-operation: next edge all state/outputs return to reset values;
//    sequence re-acquired from SEEK; counts cleared.
//  - rst held: inputs ignored, outputs stay 0.
// STRUCTURE
//  - Shared package/header: state encodings (SEEK=2'd0, ACQ=2'd1, LOCKED=2'd2),
//    CNT_MOD=8, default LOCK_CNT/UNLOCK_ERRS.
//  - One sub-module: sat_counter (CNT_W, inc, rst -> count), instanced twice
//    for err_count and wrap_count. FSM + compare stay in top.
// TESTING
//  - Drive from counter2 at clk period 10ns, rst 1 for 3 clks -> locked=1 by
//    the 7th clk after rst release; err_count=0 throughout 200 clks.
//  - Locked, run 0..7,0 -> wrap_pulse 1 clk exactly every 8 clks; after 40
//    clks wrap_count==5 (±1 for alignment, checked vs model), err_count=0.
//  - Locked, inject 3->5 skip once -> one err_pulse, err_count=1, locked
//    stays 1 (UNLOCK_ERRS=2), then next correct step clears miss_cnt.
//  - Locked, hold value 4 for 3 clks -> err_pulse 2 clks, locked drops after
//    2nd error, then re-locks after LOCK_CNT good steps; err_count=2.
//  - CNT_W=2, force 5 errors (each separated by re-lock) -> err_count
//    saturates at 3, err_pulse still fires each time.
//  - Assert rst for 1 clk while locked with err_count=3 -> next clk locked=0,
//    counts 0, pulses 0; re-lock proceeds as after power-on.

Source files
------------

// File: rtl/count_seq_checker_pkg.sv
// Shared encodings and defaults for the 3-bit count sequence checker.
package count_seq_checker_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } seq_state_e;

  localparam int CNT_MOD         = 8;
  localparam int DEF_LOCK_CNT    = 4;
  localparam int DEF_UNLOCK_ERRS = 2;

  // Expected successor of a count value, wrapping 7 -> 0.
  function automatic logic [2:0] next_count(input logic [2:0] v);
    return 3'((int'(v) + 1) % CNT_MOD);
  endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating event counter: holds at all-ones once full.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (i_inc && (r_count != '1))
      r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running 3-bit count {a,b,c}: locks onto the +1 sequence,
// then strobes and counts skips/stalls and 7->0 wraps.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int UNLOCK_ERRS = DEF_UNLOCK_ERRS,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

  seq_state_e r_state, w_state_nxt;
  logic [2:0] r_cur, r_prev;
  logic       r_filled, w_filled_nxt;
  logic [3:0] r_match, w_match_nxt;
  logic [3:0] r_miss, w_miss_nxt;
  logic       r_err_pulse, r_wrap_pulse;
  logic       w_err_evt, w_wrap_evt;
  logic       w_step_ok, w_step_wrap;

  // cur/prev are the two most recent samples; the step between them is judged here.
  assign w_step_ok   = (r_cur == next_count(r_prev));
  assign w_step_wrap = w_step_ok && (r_prev == 3'd7);

  always_comb begin
    w_state_nxt  = r_state;
    w_filled_nxt = r_filled;
    w_match_nxt  = r_match;
    w_miss_nxt   = r_miss;
    w_err_evt    = 1'b0;
    w_wrap_evt   = 1'b0;
    case (r_state)
      SEEK: begin
        // first sample only fills cur; prev becomes valid one edge later
        if (r_filled) begin
          w_state_nxt = ACQ;
          w_match_nxt = '0;
        end else begin
          w_filled_nxt = 1'b1;
        end
      end
      ACQ: begin
        if (w_step_ok) begin
          if ((r_match + 4'd1) >= LOCK_N) begin
            w_state_nxt = LOCKED;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
          end else begin
            w_match_nxt = r_match + 4'd1;
          end
        end else begin
          w_match_nxt = '0;
        end
      end
      LOCKED: begin
        if (w_step_ok) begin
          w_miss_nxt = '0;
          w_wrap_evt = w_step_wrap;
        end else begin
          w_err_evt = 1'b1;
          if ((r_miss + 4'd1) >= UNLOCK_N) begin
            w_state_nxt = ACQ;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
          end else begin
            w_miss_nxt = r_miss + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt  = SEEK;
        w_filled_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEEK;
      r_cur        <= '0;
      r_prev       <= '0;
      r_filled     <= 1'b0;
      r_match      <= '0;
      r_miss       <= '0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur        <= {a, b, c};
      r_prev       <= r_cur;
      r_filled     <= w_filled_nxt;
      r_match      <= w_match_nxt;
      r_miss       <= w_miss_nxt;
      r_err_pulse  <= w_err_evt;
      r_wrap_pulse <= w_wrap_evt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_err_evt),
    .o_count (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_wrap_evt),
    .o_count (wrap_count)
  );

  assign locked     = (r_state == LOCKED);
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;

endmodule
